// File: rtl/iomem_timer_pkg.sv
// Shared definitions for the iomem timer/compare peripheral.
// Holds register offsets, CTRL/STATUS bit positions and the byte-merge helper.
package iomem_timer_pkg;

  localparam logic [7:0] TMR_CTRL     = 8'h00;
  localparam logic [7:0] TMR_PRESCALE = 8'h04;
  localparam logic [7:0] TMR_COUNT    = 8'h08;
  localparam logic [7:0] TMR_COMPARE  = 8'h0C;
  localparam logic [7:0] TMR_STATUS   = 8'h10;

  localparam int unsigned CTRL_ENABLE      = 0;
  localparam int unsigned CTRL_AUTO_RELOAD = 1;
  localparam int unsigned CTRL_IRQ_EN      = 2;
  localparam int unsigned CTRL_W           = 3;
  localparam int unsigned STATUS_PENDING   = 0;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_PRESCALE,
    REG_COUNT,
    REG_COMPARE,
    REG_STATUS,
    REG_NONE
  } tmr_reg_e;

  function automatic tmr_reg_e decode_reg(input logic [7:0] off);
    case (off)
      TMR_CTRL:     return REG_CTRL;
      TMR_PRESCALE: return REG_PRESCALE;
      TMR_COUNT:    return REG_COUNT;
      TMR_COMPARE:  return REG_COMPARE;
      TMR_STATUS:   return REG_STATUS;
      default:      return REG_NONE;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/iomem_timer_core.sv
// Timer datapath: prescaler, 32-bit counter, compare match and sticky pending flag.
// Bus writes arrive as per-register enables plus the raw byte strobes.
module iomem_timer_core
  import iomem_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  we_ctrl_i,
  input  logic                  we_prescale_i,
  input  logic                  we_count_i,
  input  logic                  we_compare_i,
  input  logic                  we_status_i,
  input  logic [3:0]            wstrb_i,
  input  logic [31:0]           wdata_i,
  output logic [CTRL_W-1:0]     ctrl_o,
  output logic [PRESCALE_W-1:0] prescale_o,
  output logic [31:0]           count_o,
  output logic [31:0]           compare_o,
  output logic                  pending_o,
  output logic                  tick_o
);

  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic                  pending_q, pending_d;
  logic                  tick, match;

  always_comb begin
    tick  = ctrl_q[CTRL_ENABLE] && (psc_q == prescale_q);
    match = tick && (count_q == compare_q);

    ctrl_d = (we_ctrl_i && wstrb_i[0]) ? wdata_i[CTRL_W-1:0] : ctrl_q;

    prescale_d = prescale_q;
    if (we_prescale_i) begin
      for (int unsigned i = 0; i < PRESCALE_W; i++) begin
        if (wstrb_i[i/8]) prescale_d[i] = wdata_i[i];
      end
    end

    compare_d = we_compare_i ? merge_bytes(compare_q, wdata_i, wstrb_i) : compare_q;

    // Reconfiguring restarts the prescale period so the next tick is a full period away.
    if (we_ctrl_i || we_prescale_i || !ctrl_q[CTRL_ENABLE] || tick) psc_d = '0;
    else                                                           psc_d = psc_q + 1'b1;

    if (we_count_i)                           count_d = merge_bytes(count_q, wdata_i, wstrb_i);
    else if (match && ctrl_q[CTRL_AUTO_RELOAD]) count_d = '0;
    else if (tick)                            count_d = count_q + 32'd1;
    else                                      count_d = count_q;

    if (match)                                                        pending_d = 1'b1;
    else if (we_status_i && wstrb_i[0] && wdata_i[STATUS_PENDING])    pending_d = 1'b0;
    else                                                              pending_d = pending_q;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      psc_q      <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      pending_q  <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      psc_q      <= psc_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      pending_q  <= pending_d;
    end
  end

  assign ctrl_o     = ctrl_q;
  assign prescale_o = prescale_q;
  assign count_o    = count_q;
  assign compare_o  = compare_q;
  assign pending_o  = pending_q;
  assign tick_o     = tick;

endmodule

// File: rtl/iomem_timer.sv
// PicoSoC iomem responder wrapping the timer core: window decode, one-wait-state
// handshake, write routing and registered read mux.
module iomem_timer
  import iomem_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  logic                  ready_q, ready_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  in_window, accept, wr;
  tmr_reg_e              sel;
  logic [31:0]           rd_mux;
  logic [CTRL_W-1:0]     ctrl;
  logic [PRESCALE_W-1:0] prescale;
  logic [31:0]           count, compare;
  logic                  pending;
  logic                  tick_unused;

  assign sel       = decode_reg(iomem_addr[7:0]);
  assign in_window = (iomem_addr[31:8] == BASE_ADDR[31:8]);
  // Blocking on ready_q keeps a still-held valid from being accepted twice.
  assign accept    = iomem_valid && in_window && !ready_q;
  assign wr        = accept && (|iomem_wstrb);

  iomem_timer_core #(
    .PRESCALE_W(PRESCALE_W)
  ) u_core (
    .clk          (clk),
    .rst_i        (reset),
    .we_ctrl_i    (wr && (sel == REG_CTRL)),
    .we_prescale_i(wr && (sel == REG_PRESCALE)),
    .we_count_i   (wr && (sel == REG_COUNT)),
    .we_compare_i (wr && (sel == REG_COMPARE)),
    .we_status_i  (wr && (sel == REG_STATUS)),
    .wstrb_i      (iomem_wstrb),
    .wdata_i      (iomem_wdata),
    .ctrl_o       (ctrl),
    .prescale_o   (prescale),
    .count_o      (count),
    .compare_o    (compare),
    .pending_o    (pending),
    .tick_o       (tick_unused)
  );

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_CTRL:     rd_mux = 32'(ctrl);
      REG_PRESCALE: rd_mux = 32'(prescale);
      REG_COUNT:    rd_mux = count;
      REG_COMPARE:  rd_mux = compare;
      REG_STATUS:   rd_mux = 32'(pending);
      default:      rd_mux = '0;
    endcase
  end

  always_comb begin
    ready_d = accept;
    rdata_d = accept ? rd_mux : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq         = pending & ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_iomem_timer.sv
// Bench for iomem_timer: per-cycle reference model of the bus and timer, a vector
// table, directed corner-case sequences and randomized bus traffic.
module tb_iomem_timer;
  import iomem_timer_pkg::*;

  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  always #5 clk = ~clk;

  iomem_timer #(
    .BASE_ADDR (BASE),
    .PRESCALE_W(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .iomem_valid(valid),
    .iomem_ready(ready),
    .iomem_wstrb(wstrb),
    .iomem_addr (addr),
    .iomem_wdata(wdata),
    .iomem_rdata(rdata),
    .irq        (irq)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the prescaler is a count of enabled cycles since its last
  // restart; a tick falls on every (PRESCALE+1)-th of them.
  logic [2:0]  m_ctrl;
  logic [15:0] m_presc;
  logic [31:0] m_count, m_compare;
  logic        m_pending, m_ready;
  logic [31:0] m_rdata;
  int unsigned m_run;

  function automatic logic [31:0] strobe_mix(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic bit m_tick();
    return m_ctrl[0] && ((m_run % (32'(m_presc) + 32'd1)) == 32'(m_presc));
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] off);
    case (off)
      8'h00:   return {29'd0, m_ctrl};
      8'h04:   return {16'd0, m_presc};
      8'h08:   return m_count;
      8'h0C:   return m_compare;
      8'h10:   return {31'd0, m_pending};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_presc = '0; m_count = '0; m_compare = '0;
    m_pending = 1'b0; m_ready = 1'b0; m_rdata = '0; m_run = 0;
  endtask

  task automatic model_edge(input logic v, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d);
    logic        acc, wr, tk, hit;
    logic [7:0]  off;
    logic [31:0] nrd, t;
    acc = v && (a[31:8] == BASE[31:8]) && !m_ready;
    wr  = acc && (s != 4'd0);
    off = a[7:0];
    tk  = m_tick();
    hit = tk && (m_count == m_compare);
    nrd = acc ? m_read(off) : 32'd0;
    if (wr && off == 8'h08)  m_count = strobe_mix(m_count, d, s);
    else if (tk)             m_count = (hit && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
    if (hit)                                          m_pending = 1'b1;
    else if (wr && off == 8'h10 && s[0] && d[0])      m_pending = 1'b0;
    if ((wr && (off == 8'h00 || off == 8'h04)) || !m_ctrl[0]) m_run = 0;
    else                                                       m_run++;
    if (wr && off == 8'h00) begin
      t = strobe_mix({29'd0, m_ctrl}, d, s);
      m_ctrl = t[2:0];
    end
    if (wr && off == 8'h04) begin
      t = strobe_mix({16'd0, m_presc}, d, s);
      m_presc = t[15:0];
    end
    if (wr && off == 8'h0C) m_compare = strobe_mix(m_compare, d, s);
    m_ready = acc;
    m_rdata = nrd;
  endtask

  // One clock: drive inputs, advance the model, then compare all outputs.
  task automatic step(input logic v, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d);
    valid = v; addr = a; wstrb = s; wdata = d;
    model_edge(v, a, s, d);
    @(posedge clk);
    #1;
    check("ready", {31'd0, ready}, {31'd0, m_ready});
    check("rdata", rdata, m_rdata);
    check("irq", {31'd0, irq}, {31'd0, m_pending & m_ctrl[2]});
  endtask

  task automatic xact(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] rd, output logic ack);
    step(1'b1, a, s, d);
    rd  = rdata;
    ack = ready;
    if (a[31:8] != BASE[31:8]) begin
      step(1'b1, a, s, d);
      step(1'b1, a, s, d);
    end
    step(1'b0, 32'd0, 4'd0, 32'd0);
  endtask

  task automatic wr_reg(input logic [7:0] off, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] rd;
    logic        ack;
    xact(BASE | 32'(off), s, d, rd, ack);
  endtask

  task automatic rd_expect(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    logic        ack;
    xact(BASE | 32'(off), 4'd0, 32'd0, rd, ack);
    check(name, rd, exp);
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        exp_ack;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic run_vec(input vec_t v);
    logic [31:0] rd;
    logic        ack;
    xact(v.addr, v.wstrb, v.wdata, rd, ack);
    check({v.name, "_ack"}, {31'd0, ack}, {31'd0, v.exp_ack});
    if (v.chk_rd) check(v.name, rd, v.exp_rd);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, rd;
    logic [3:0]  s;
    logic        ack;
    int unsigned n, r;

    tbl.push_back('{"rst_ctrl",     BASE | 32'h00, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0});
    tbl.push_back('{"rst_prescale", BASE | 32'h04, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0});
    tbl.push_back('{"rst_count",    BASE | 32'h08, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0});
    tbl.push_back('{"rst_compare",  BASE | 32'h0C, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0});
    tbl.push_back('{"rst_status",   BASE | 32'h10, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0});
    tbl.push_back('{"cmp_byte1_wr", BASE | 32'h0C, 4'h2, 32'hAABBCCDD,  1'b1, 1'b0, 32'h0});
    tbl.push_back('{"cmp_byte1_rd", BASE | 32'h0C, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0000CC00});
    tbl.push_back('{"outside_rd",   32'h0400_0000, 4'h0, 32'h0,         1'b0, 1'b1, 32'h0});
    tbl.push_back('{"outside_wr",   32'h0400_0008, 4'hF, 32'h12345678,  1'b0, 1'b0, 32'h0});
    tbl.push_back('{"hole_wr",      BASE | 32'h20, 4'hF, 32'hFFFFFFFF,  1'b1, 1'b0, 32'h0});
    tbl.push_back('{"hole_rd",      BASE | 32'h20, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0});
    tbl.push_back('{"count_intact", BASE | 32'h08, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0});
    tbl.push_back('{"prescale_w",   BASE | 32'h04, 4'hF, 32'hDEAD0007,  1'b1, 1'b0, 32'h0});
    tbl.push_back('{"prescale_rd",  BASE | 32'h04, 4'h0, 32'h0,         1'b1, 1'b1, 32'h00000007});

    reset = 1'b1; valid = 1'b0; addr = '0; wstrb = '0; wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Prescale 3, compare 5, all CTRL bits: irq 24 cycles after the CTRL write edge.
    wr_reg(TMR_PRESCALE, 4'hF, 32'd3);
    wr_reg(TMR_COMPARE, 4'hF, 32'd5);
    step(1'b1, BASE | 32'h00, 4'hF, 32'd7);
    step(1'b0, 32'd0, 4'd0, 32'd0);
    n = 1;
    while (!irq && n < 100) begin
      step(1'b0, 32'd0, 4'd0, 32'd0);
      n++;
    end
    check("irq_latency", n, 32'd24);
    rd_expect("reload_count", TMR_COUNT, 32'd0);
    rd_expect("pending_set", TMR_STATUS, 32'd1);
    step(1'b1, BASE | 32'h10, 4'h1, 32'd1);
    check("w1c_irq_clear", {31'd0, irq}, 32'd0);
    step(1'b0, 32'd0, 4'd0, 32'd0);
    wr_reg(TMR_CTRL, 4'hF, 32'd0);

    // Wrap at 0xFFFF_FFFF with prescale 0; no flag until COUNT meets COMPARE.
    wr_reg(TMR_PRESCALE, 4'hF, 32'd0);
    wr_reg(TMR_COMPARE, 4'hF, 32'h10);
    wr_reg(TMR_COUNT, 4'hF, 32'hFFFF_FFFE);
    wr_reg(TMR_STATUS, 4'h1, 32'd1);
    wr_reg(TMR_CTRL, 4'hF, 32'd1);
    rd_expect("wrap_ffff", TMR_COUNT, 32'hFFFF_FFFF);
    rd_expect("wrap_past0", TMR_COUNT, 32'h0000_0001);
    rd_expect("wrap_noflag", TMR_STATUS, 32'd0);
    repeat (16) step(1'b0, 32'd0, 4'd0, 32'd0);
    rd_expect("wrap_match", TMR_STATUS, 32'd1);
    wr_reg(TMR_CTRL, 4'hF, 32'd0);

    // COUNT write on a tick edge, then W1C on a match edge.
    wr_reg(TMR_COMPARE, 4'hF, 32'h105);
    wr_reg(TMR_STATUS, 4'h1, 32'd1);
    wr_reg(TMR_CTRL, 4'hF, 32'd1);
    step(1'b1, BASE | 32'h08, 4'hF, 32'h100);
    step(1'b0, 32'd0, 4'd0, 32'd0);
    rd_expect("count_write_wins", TMR_COUNT, 32'h101);
    n = 0;
    while (!(m_tick() && m_count == m_compare) && n < 50) begin
      step(1'b0, 32'd0, 4'd0, 32'd0);
      n++;
    end
    check("match_wait", n, 32'd2);
    step(1'b1, BASE | 32'h10, 4'h1, 32'd1);
    step(1'b0, 32'd0, 4'd0, 32'd0);
    rd_expect("match_beats_w1c", TMR_STATUS, 32'd1);
    wr_reg(TMR_CTRL, 4'hF, 32'd0);

    // valid held through the ready cycle: ready still lasts one cycle.
    step(1'b1, BASE | 32'h0C, 4'h0, 32'd0);
    step(1'b1, BASE | 32'h0C, 4'h0, 32'd0);
    check("ready_one_cycle", {31'd0, ready}, 32'd0);
    step(1'b0, 32'd0, 4'd0, 32'd0);
    step(1'b0, 32'd0, 4'd0, 32'd0);

    for (int unsigned it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      s = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(1, 15));
      d = $urandom();
      case (r)
        0: begin a = BASE | 32'h00; d = 32'($urandom_range(0, 7)); end
        1: begin a = BASE | 32'h04; d = 32'($urandom_range(0, 3)); end
        2: a = BASE | 32'h08;
        3: begin a = BASE | 32'h0C; d = m_count + 32'($urandom_range(0, 12)); end
        4: a = BASE | 32'h10;
        5: a = BASE | 32'($urandom_range(5, 63) * 4);
        6: begin
          a = $urandom();
          if (a[31:8] == BASE[31:8]) a[31] = ~a[31];
        end
        default: begin
          a = BASE | 32'($urandom_range(0, 4) * 4);
          s = 4'h0;
        end
      endcase
      xact(a, s, d, rd, ack);
      repeat ($urandom_range(0, 3)) step(1'b0, 32'd0, 4'd0, 32'd0);
    end

    // Reset asserted while a request waits for its acknowledge.
    wr_reg(TMR_PRESCALE, 4'hF, 32'd2);
    wr_reg(TMR_COUNT, 4'hF, 32'h1234);
    wr_reg(TMR_COMPARE, 4'hF, 32'h40);
    wr_reg(TMR_CTRL, 4'hF, 32'd7);
    valid = 1'b1; addr = BASE | 32'h08; wstrb = 4'h0; wdata = '0;
    #2 reset = 1'b1;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    check("abort_no_ack", {31'd0, ready}, 32'd0);
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int unsigned i = 0; i < 5; i++) run_vec(tbl[i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
